// File: rtl/board_ram.sv
// board_ram: single-clock X_SIZE x Y_SIZE board store with two registered read ports,
// one write port and a clear sweep. Optional cell counter enabled by `define BOARD_RAM_CNT_EN.
module board_ram #(
  parameter int X_SIZE       = 12,
  parameter int Y_SIZE       = 12,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH   = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] COUNT_VALUE = DATA_WIDTH'(1),
  localparam int AW = X_ADDR_WIDTH + Y_ADDR_WIDTH,
  localparam int CW = $clog2(X_SIZE * Y_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_drop,
  input  logic [AW-1:0]         rd_a_addr,
  output logic [DATA_WIDTH-1:0] rd_a_data,
  input  logic [AW-1:0]         rd_b_addr,
  output logic [DATA_WIDTH-1:0] rd_b_data
`ifdef BOARD_RAM_CNT_EN
  ,
  output logic [CW-1:0]         cell_cnt
`endif
);

  localparam logic [X_ADDR_WIDTH:0]   X_LIM  = (X_ADDR_WIDTH + 1)'(X_SIZE);
  localparam logic [Y_ADDR_WIDTH:0]   Y_LIM  = (Y_ADDR_WIDTH + 1)'(Y_SIZE);
  localparam logic [X_ADDR_WIDTH-1:0] X_LAST = X_ADDR_WIDTH'(X_SIZE - 1);
  localparam logic [Y_ADDR_WIDTH-1:0] Y_LAST = Y_ADDR_WIDTH'(Y_SIZE - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, state_n;
  logic [X_ADDR_WIDTH-1:0] sx, sx_n;
  logic [Y_ADDR_WIDTH-1:0] sy, sy_n;

  logic [X_ADDR_WIDTH-1:0] wr_x, rd_a_x, rd_b_x, mem_x;
  logic [Y_ADDR_WIDTH-1:0] wr_y, rd_a_y, rd_b_y, mem_y;
  logic                    wr_in_range, rd_a_ok, rd_b_ok, wr_ok;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wd;

`ifdef BOARD_RAM_CNT_EN
  (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [X_SIZE][Y_SIZE];
`else
  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [X_SIZE][Y_SIZE];
`endif

  assign wr_x   = wr_addr[AW-1:Y_ADDR_WIDTH];
  assign wr_y   = wr_addr[Y_ADDR_WIDTH-1:0];
  assign rd_a_x = rd_a_addr[AW-1:Y_ADDR_WIDTH];
  assign rd_a_y = rd_a_addr[Y_ADDR_WIDTH-1:0];
  assign rd_b_x = rd_b_addr[AW-1:Y_ADDR_WIDTH];
  assign rd_b_y = rd_b_addr[Y_ADDR_WIDTH-1:0];

  assign wr_in_range = ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);
  assign rd_a_ok     = ({1'b0, rd_a_x} < X_LIM) && ({1'b0, rd_a_y} < Y_LIM);
  assign rd_b_ok     = ({1'b0, rd_b_x} < X_LIM) && ({1'b0, rd_b_y} < Y_LIM);
  assign wr_ok       = (state == IDLE) && wr_en && wr_in_range;
  assign busy        = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      sx    <= '0;
      sy    <= '0;
    end else begin
      state <= state_n;
      sx    <= sx_n;
      sy    <= sy_n;
    end
  end

  // Sweep walks y fastest; the write port is shared between sweep and user writes.
  always_comb begin
    state_n = state;
    sx_n    = sx;
    sy_n    = sy;
    mem_we  = 1'b0;
    mem_x   = wr_x;
    mem_y   = wr_y;
    mem_wd  = wr_data;
    case (state)
      IDLE: begin
        mem_we = wr_ok;
        if (clear_req) begin
          state_n = CLEAR;
          sx_n    = '0;
          sy_n    = '0;
        end
      end
      CLEAR: begin
        mem_we = 1'b1;
        mem_x  = sx;
        mem_y  = sy;
        mem_wd = CLEAR_VALUE;
        if (sy == Y_LAST) begin
          sy_n = '0;
          if (sx == X_LAST) state_n = IDLE;
          else              sx_n    = sx + X_ADDR_WIDTH'(1);
        end else begin
          sy_n = sy + Y_ADDR_WIDTH'(1);
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_x][mem_y] <= mem_wd;
  end

  // Non-blocking reads against the same-edge write give read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_data <= '0;
      rd_b_data <= '0;
      wr_drop   <= 1'b0;
    end else begin
      rd_a_data <= rd_a_ok ? mem[rd_a_x][rd_a_y] : CLEAR_VALUE;
      rd_b_data <= rd_b_ok ? mem[rd_b_x][rd_b_y] : CLEAR_VALUE;
      wr_drop   <= wr_en && !wr_ok;
    end
  end

`ifdef BOARD_RAM_CNT_EN
  localparam int            CNT_INIT_I = (CLEAR_VALUE == COUNT_VALUE) ? X_SIZE * Y_SIZE : 0;
  localparam logic [CW-1:0] CNT_INIT   = CW'(CNT_INIT_I);

  logic [DATA_WIDTH-1:0] old_cell;
  logic                  clr_start;

  assign old_cell  = mem[wr_x][wr_y];
  assign clr_start = (state == IDLE) && clear_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cell_cnt <= CNT_INIT;
    end else if (clr_start) begin
      cell_cnt <= CNT_INIT;
    end else if (wr_ok) begin
      if (old_cell != COUNT_VALUE && wr_data == COUNT_VALUE)
        cell_cnt <= cell_cnt + CW'(1);
      else if (old_cell == COUNT_VALUE && wr_data != COUNT_VALUE)
        cell_cnt <= cell_cnt - CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_board_ram.sv
// Self-checking bench for board_ram (12x12, 2-bit cells, CLEAR_VALUE=0, COUNT_VALUE=1).
module tb_board_ram;
  logic       clk = 1'b0;
  logic       rst, clear_req, wr_en;
  logic [7:0] wr_addr, rd_a_addr, rd_b_addr;
  logic [1:0] wr_data;
  logic       busy, wr_drop;
  logic [1:0] rd_a_data, rd_b_data;
`ifdef BOARD_RAM_CNT_EN
  logic [7:0] cell_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [1:0] model [12][12];
  logic [1:0] exp_a_q[$];
  logic [1:0] exp_b_q[$];

  board_ram dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data)
`ifdef BOARD_RAM_CNT_EN
    , .cell_cnt(cell_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_rd(input logic [7:0] a);
    if (a[7:4] < 12 && a[3:0] < 12) return model[a[7:4]][a[3:0]];
    return 2'd0;
  endfunction

  task automatic clear_model;
    for (int x = 0; x < 12; x++)
      for (int y = 0; y < 12; y++) model[x][y] = 2'd0;
  endtask

  function automatic int count_model;
    int n = 0;
    for (int x = 0; x < 12; x++)
      for (int y = 0; y < 12; y++) if (model[x][y] == 2'd1) n++;
    return n;
  endfunction

  task automatic drive_read(input logic [7:0] a, input logic [7:0] b);
    rd_a_addr = a;
    rd_b_addr = b;
    exp_a_q.push_back(model_rd(a));
    exp_b_q.push_back(model_rd(b));
  endtask

  task automatic test_reset;
    int n;
    logic [1:0] ea, eb;
    rst = 1'b1; clear_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_a_addr = '0; rd_b_addr = '0;
    clear_model();
    step(); step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %0b exp 1", busy); end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL rst_wr_drop got %0b exp 0", wr_drop); end
    checks++; if (rd_a_data !== 2'd0) begin errors++; $display("FAIL rst_rd_a got %0h exp 0", rd_a_data); end
    checks++; if (rd_b_data !== 2'd0) begin errors++; $display("FAIL rst_rd_b got %0h exp 0", rd_b_data); end
`ifdef BOARD_RAM_CNT_EN
    checks++; if (cell_cnt !== 8'd0) begin errors++; $display("FAIL rst_cell_cnt got %0d exp 0", cell_cnt); end
`endif
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin step(); n++; end
    checks++; if (n != 144) begin errors++; $display("FAIL init_sweep_len got %0d exp 144", n); end
    for (int x = 0; x < 12; x++)
      for (int y = 0; y < 12; y++) begin
        drive_read({x[3:0], y[3:0]}, {y[3:0], x[3:0]});
        step();
        ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
        checks++; if (rd_a_data !== ea) begin errors++; $display("FAIL init_rd_a x=%0d y=%0d got %0h exp %0h", x, y, rd_a_data, ea); end
        checks++; if (rd_b_data !== eb) begin errors++; $display("FAIL init_rd_b x=%0d y=%0d got %0h exp %0h", y, x, rd_b_data, eb); end
      end
  endtask

  task automatic test_write_read;
    logic [7:0] addrs [4] = '{8'h35, 8'hBB, 8'h00, 8'hB0};
    logic [1:0] vals  [4] = '{2'd2, 2'd3, 2'd1, 2'd2};
    logic [1:0] ea, eb;
    for (int i = 0; i < 4; i++) begin
      drive_read(8'h00, addrs[i]);
      wr_en = 1'b1; wr_addr = addrs[i]; wr_data = vals[i];
      step();
      model[addrs[i][7:4]][addrs[i][3:0]] = vals[i];
      wr_en = 1'b0;
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      checks++; if (rd_a_data !== ea) begin errors++; $display("FAIL wr_same_edge_a addr=%0h got %0h exp %0h", addrs[i], rd_a_data, ea); end
      checks++; if (rd_b_data !== eb) begin errors++; $display("FAIL wr_read_first_b addr=%0h got %0h exp %0h", addrs[i], rd_b_data, eb); end
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL wr_accept_drop addr=%0h got %0b exp 0", addrs[i], wr_drop); end
      drive_read(addrs[i], addrs[i]);
      step();
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      checks++; if (rd_a_data !== ea) begin errors++; $display("FAIL wr_after_a addr=%0h got %0h exp %0h", addrs[i], rd_a_data, ea); end
      checks++; if (rd_b_data !== eb) begin errors++; $display("FAIL wr_after_b addr=%0h got %0h exp %0h", addrs[i], rd_b_data, eb); end
    end
  endtask

  task automatic test_out_of_range;
    logic [7:0] bad [4] = '{8'hC0, 8'h0C, 8'hFF, 8'h5C};
    logic [7:0] rda [4] = '{8'hC0, 8'h00, 8'h50, 8'hB0};
    logic [7:0] rdb [4] = '{8'h0C, 8'h05, 8'hBB, 8'h35};
    logic [1:0] ea, eb;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = bad[i]; wr_data = 2'd3;
      step();
      wr_en = 1'b0;
      checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL oor_drop addr=%0h got %0b exp 1", bad[i], wr_drop); end
      step();
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL oor_drop_clear addr=%0h got %0b exp 0", bad[i], wr_drop); end
    end
    for (int i = 0; i < 4; i++) begin
      drive_read(rda[i], rdb[i]);
      step();
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      checks++; if (rd_a_data !== ea) begin errors++; $display("FAIL oor_rd_a addr=%0h got %0h exp %0h", rda[i], rd_a_data, ea); end
      checks++; if (rd_b_data !== eb) begin errors++; $display("FAIL oor_rd_b addr=%0h got %0h exp %0h", rdb[i], rd_b_data, eb); end
    end
  endtask

  task automatic test_busy_drop;
    logic [1:0] ea, eb;
    clear_req = 1'b1; wr_en = 1'b1; wr_addr = 8'h12; wr_data = 2'd1;
    step();
    clear_model();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_start got %0b exp 1", busy); end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL clr_same_edge_drop got %0b exp 0", wr_drop); end
    wr_addr = 8'h35; wr_data = 2'd3;
    for (int i = 1; i <= 144; i++) begin
      if (i == 5) clear_req = 1'b0;
      step();
      checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL busy_drop cycle=%0d got %0b exp 1", i, wr_drop); end
      checks++; if (busy !== (i < 144)) begin errors++; $display("FAIL busy_len cycle=%0d got %0b exp %0b", i, busy, (i < 144)); end
    end
    wr_en = 1'b0;
    step();
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL busy_drop_end got %0b exp 0", wr_drop); end
    for (int x = 0; x < 12; x++)
      for (int y = 0; y < 12; y++) begin
        drive_read({x[3:0], y[3:0]}, {y[3:0], x[3:0]});
        step();
        ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
        checks++; if (rd_a_data !== ea) begin errors++; $display("FAIL clr_rd_a x=%0d y=%0d got %0h exp %0h", x, y, rd_a_data, ea); end
        checks++; if (rd_b_data !== eb) begin errors++; $display("FAIL clr_rd_b x=%0d y=%0d got %0h exp %0h", y, x, rd_b_data, eb); end
      end
  endtask

  task automatic test_rst_mid_sweep;
    int n;
    logic [1:0] ea, eb;
    logic [7:0] wa [3] = '{8'h00, 8'hBB, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = wa[i]; wr_data = 2'd2;
      step();
    end
    wr_en = 1'b0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (70) step();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy got %0b exp 1", busy); end
    checks++; if (rd_a_data !== 2'd0) begin errors++; $display("FAIL mid_rst_rd_a got %0h exp 0", rd_a_data); end
    step(); step();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin step(); n++; end
    checks++; if (n != 144) begin errors++; $display("FAIL mid_rst_sweep_len got %0d exp 144", n); end
    clear_model();
    for (int i = 0; i < 3; i++) begin
      drive_read(wa[i], wa[(i + 1) % 3]);
      step();
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      checks++; if (rd_a_data !== ea) begin errors++; $display("FAIL mid_rst_rd_a addr=%0h got %0h exp %0h", wa[i], rd_a_data, ea); end
      checks++; if (rd_b_data !== eb) begin errors++; $display("FAIL mid_rst_rd_b addr=%0h got %0h exp %0h", wa[(i + 1) % 3], rd_b_data, eb); end
    end
  endtask

`ifdef BOARD_RAM_CNT_EN
  task automatic test_count;
    logic [7:0] addrs [5] = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h33};
    logic [1:0] vals  [5] = '{2'd1, 2'd1, 2'd3, 2'd1, 2'd0};
    int exp_cnt, n;
    checks++; if (cell_cnt !== 8'(count_model())) begin errors++; $display("FAIL cnt_start got %0d exp %0d", cell_cnt, count_model()); end
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = addrs[i]; wr_data = vals[i];
      step();
      wr_en = 1'b0;
      model[addrs[i][7:4]][addrs[i][3:0]] = vals[i];
      exp_cnt = count_model();
      checks++; if (cell_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL cnt_write i=%0d got %0d exp %0d", i, cell_cnt, exp_cnt); end
    end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    clear_model();
    checks++; if (cell_cnt !== 8'd0) begin errors++; $display("FAIL cnt_clear got %0d exp 0", cell_cnt); end
    n = 0;
    while (busy === 1'b1 && n < 1000) begin step(); n++; end
    checks++; if (n != 144) begin errors++; $display("FAIL cnt_sweep_len got %0d exp 144", n); end
    checks++; if (cell_cnt !== 8'd0) begin errors++; $display("FAIL cnt_after_sweep got %0d exp 0", cell_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_busy_drop();
    test_rst_mid_sweep();
`ifdef BOARD_RAM_CNT_EN
    test_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
